// File: rtl/dp_ram_be_if.sv
// Bus bundle for the dual-port byte-enable RAM: two independent access ports
// plus the shared ready flag.
interface dp_ram_be_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int BYTE_W = 8
);
    localparam int NB = DATA_W / BYTE_W;

    logic              ready;

    logic              ena;
    logic [NB-1:0]     wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;
    logic              vala;

    logic              enb;
    logic [NB-1:0]     web;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dinb;
    logic [DATA_W-1:0] doutb;
    logic              valb;

    modport master (
        input  ready,
        output ena, wea, addra, dina,
        input  douta, vala,
        output enb, web, addrb, dinb,
        input  doutb, valb
    );

    modport slave (
        output ready,
        input  ena, wea, addra, dina,
        output douta, vala,
        input  enb, web, addrb, dinb,
        output doutb, valb
    );
endinterface

// File: rtl/dp_ram_be.sv
// True dual-port synchronous RAM with per-byte write enables, optional output
// register, selectable same-port read-during-write and optional zero-fill after reset.
module dp_ram_be #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 12,
    parameter int BYTE_W    = 8,
    parameter int OUT_REG   = 0,
    parameter int RDW_MODE  = 0,
    parameter int INIT_ZERO = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    dp_ram_be_if.slave bus
);
    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    if (DATA_W % BYTE_W != 0) begin : g_width_check
        $error("dp_ram_be: DATA_W must be a multiple of BYTE_W");
    end

    typedef enum logic [1:0] {ST_INIT, ST_WAIT, ST_RUN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clrAddr_q, clrAddr_d;
    logic              clrWe;
    logic              run;
    logic              accA, accB;
    logic [DATA_W-1:0] oldA, oldB, rdA, rdB;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic [DATA_W-1:0] mergeLanes(input logic [DATA_W-1:0] oldWord,
                                                     input logic [DATA_W-1:0] wrWord,
                                                     input logic [NB-1:0]     be);
        logic [DATA_W-1:0] res;
        res = oldWord;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) res[i*BYTE_W +: BYTE_W] = wrWord[i*BYTE_W +: BYTE_W];
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (INIT_ZERO != 0) state_q <= ST_INIT;
            else                state_q <= ST_WAIT;
            clrAddr_q <= '0;
        end else begin
            state_q   <= state_d;
            clrAddr_q <= clrAddr_d;
        end
    end

    // The zero-fill walks every address once; the edge that clears the last word opens the RAM.
    always_comb begin
        state_d   = state_q;
        clrAddr_d = clrAddr_q;
        clrWe     = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                clrWe     = 1'b1;
                clrAddr_d = clrAddr_q + ADDR_W'(1);
                if (clrAddr_q == '1) state_d = ST_RUN;
            end
            ST_WAIT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    assign run       = (state_q == ST_RUN);
    assign bus.ready = run;
    assign accA      = run && bus.ena;
    assign accB      = run && bus.enb;

    assign oldA = mem[bus.addra];
    assign oldB = mem[bus.addrb];
    // Write-first only merges the port's own lanes, so a cross-port reader always sees the old word.
    assign rdA  = (RDW_MODE != 0) ? mergeLanes(oldA, bus.dina, bus.wea) : oldA;
    assign rdB  = (RDW_MODE != 0) ? mergeLanes(oldB, bus.dinb, bus.web) : oldB;

    // Port A's lane writes are issued last so it wins same-address, same-lane collisions.
    always_ff @(posedge clk) begin
        if (clrWe && rst_n) begin
            mem[clrAddr_q] <= '0;
        end
        for (int i = 0; i < NB; i++) begin
            if (accB && bus.web[i]) mem[bus.addrb][i*BYTE_W +: BYTE_W] <= bus.dinb[i*BYTE_W +: BYTE_W];
            if (accA && bus.wea[i]) mem[bus.addra][i*BYTE_W +: BYTE_W] <= bus.dina[i*BYTE_W +: BYTE_W];
        end
    end

    logic [DATA_W-1:0] rdDataA1_q, rdDataB1_q;
    logic              rdValA1_q, rdValB1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdDataA1_q <= '0;
            rdDataB1_q <= '0;
            rdValA1_q  <= 1'b0;
            rdValB1_q  <= 1'b0;
        end else begin
            if (accA) rdDataA1_q <= rdA;
            if (accB) rdDataB1_q <= rdB;
            rdValA1_q <= accA;
            rdValB1_q <= accB;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] rdDataA2_q, rdDataB2_q;
        logic              rdValA2_q, rdValB2_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdDataA2_q <= '0;
                rdDataB2_q <= '0;
                rdValA2_q  <= 1'b0;
                rdValB2_q  <= 1'b0;
            end else begin
                if (rdValA1_q) rdDataA2_q <= rdDataA1_q;
                if (rdValB1_q) rdDataB2_q <= rdDataB1_q;
                rdValA2_q <= rdValA1_q;
                rdValB2_q <= rdValB1_q;
            end
        end

        assign bus.douta = rdDataA2_q;
        assign bus.doutb = rdDataB2_q;
        assign bus.vala  = rdValA2_q;
        assign bus.valb  = rdValB2_q;
    end else begin : g_no_out_reg
        assign bus.douta = rdDataA1_q;
        assign bus.doutb = rdDataB1_q;
        assign bus.vala  = rdValA1_q;
        assign bus.valb  = rdValB1_q;
    end
endmodule
